// File: rtl/cbus_arbiter_if.sv
// cbus_arbiter_if: cbus payload types and the arbiter's request/response bundle
// slave is the arbiter's view, master is the view of the pipeline/MMU side that drives it
package common;
    typedef enum logic [2:0] {MLEN1, MLEN2, MLEN4, MLEN8, MLEN16} mlen_t;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        mlen_t       len;
        logic [63:0] addr;
        logic [63:0] data;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

interface cbus_arbiter_if;
    common::cbus_req_t  ireq;
    common::cbus_resp_t iresp;
    common::cbus_req_t  dreq;
    common::cbus_resp_t dresp;
    common::cbus_req_t  oreq;
    common::cbus_resp_t oresp;
    logic [1:0]         owner;
    logic               busy;
    modport slave (
        input  ireq, dreq, oresp,
        output iresp, dresp, oreq, owner, busy
    );
    modport master (
        output ireq, dreq, oresp,
        input  iresp, dresp, oreq, owner, busy
    );
endinterface

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: 2:1 fetch/data arbiter in front of the MMU cbus port, grant held until ready&&last
// CBUS_ARB_RR_EN selects round-robin tie-break; undefined means data always wins a tie
module cbus_arbiter (
    input  logic           clk,
    input  logic           rst_n,
    cbus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, GAP} state_t;
    state_t state;
    logic   last_d;
    logic   pick_d;
    logic   done;
    assign done = bus.oresp.ready && bus.oresp.last;
`ifdef CBUS_ARB_RR_EN
    assign pick_d = ~last_d;
`else
    // last_served is still tracked, but a tie always goes to data
    assign pick_d = ~last_d | 1'b1;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (bus.ireq.valid && bus.dreq.valid) state <= pick_d ? GRANT_D : GRANT_I;
                    else if (bus.dreq.valid)              state <= GRANT_D;
                    else if (bus.ireq.valid)              state <= GRANT_I;
                GRANT_I:
                    if (done) begin
                        state  <= GAP;
                        last_d <= 1'b0;
                    end
                GRANT_D:
                    if (done) begin
                        state  <= GAP;
                        last_d <= 1'b1;
                    end
                GAP:
                    state <= IDLE;
            endcase
        end
    end
    assign bus.oreq  = state == GRANT_I ? bus.ireq : state == GRANT_D ? bus.dreq : '0;
    assign bus.iresp = state == GRANT_I ? bus.oresp : '0;
    assign bus.dresp = state == GRANT_D ? bus.oresp : '0;
    assign bus.owner = {state == GRANT_D, state == GRANT_I};
    assign bus.busy  = state != IDLE;
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: vector table, corner sequences and randomized traffic against a reference model
module tb_cbus_arbiter;
    import common::*;
    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    cbus_arbiter_if bus();
    cbus_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    typedef struct packed {
        logic       iv;
        logic       dv;
        logic       rdy;
        logic       lst;
        logic [1:0] own;
        logic       busy;
    } vec_t;
    task automatic step();
        @(negedge clk);
    endtask
    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    // expected outputs follow from who owns the bus and what the bench is driving
    task automatic chk_all(input string tag, input int own, input logic busy);
        cbus_req_t  er;
        cbus_resp_t ei;
        cbus_resp_t ed;
        er = own == 1 ? bus.ireq : own == 2 ? bus.dreq : '0;
        ei = own == 1 ? bus.oresp : '0;
        ed = own == 2 ? bus.oresp : '0;
        chk({tag, ".owner"}, 160'(bus.owner), 160'(own));
        chk({tag, ".busy"},  160'(bus.busy),  160'(busy));
        chk({tag, ".oreq"},  160'(bus.oreq),  160'(er));
        chk({tag, ".iresp"}, 160'(bus.iresp), 160'(ei));
        chk({tag, ".dresp"}, 160'(bus.dresp), 160'(ed));
    endtask
    function automatic cbus_req_t mkreq(input logic [63:0] a, input logic wr);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = 3'd3;
        r.len      = mlen_t'($urandom_range(0, 4));
        r.addr     = a;
        r.data     = {$urandom, $urandom};
        return r;
    endfunction
    task automatic do_reset();
        rst_n     = 1'b0;
        bus.ireq  = '0;
        bus.dreq  = '0;
        bus.oresp = '{ready: 1'b1, last: 1'b1, data: 64'hdead};
        #3;
        chk_all("reset", 0, 1'b0);
        step();
        step();
        rst_n     = 1'b1;
        bus.oresp = '0;
    endtask
    vec_t      tbl [15];
    cbus_req_t ir;
    cbus_req_t dr;
    cbus_req_t br;
    int        n;
    int        exp_own;
    int        m_own;
    int        m_last;
    bit        m_gap;
    bit        fin_i;
    bit        fin_d;
    initial begin
        total  = 0;
        passed = 0;
        tbl[0]  = 7'b1000_00_0;
        tbl[1]  = 7'b1000_01_1;
        tbl[2]  = 7'b1010_01_1;
        tbl[3]  = 7'b1011_01_1;
        tbl[4]  = 7'b1100_00_1;
        tbl[5]  = 7'b0111_00_0;
        tbl[6]  = 7'b0100_10_1;
        tbl[7]  = 7'b0000_10_1;
        tbl[8]  = 7'b0011_10_1;
        tbl[9]  = 7'b1100_00_1;
        tbl[10] = 7'b1000_00_0;
        tbl[11] = 7'b1001_01_1;
        tbl[12] = 7'b1011_01_1;
        tbl[13] = 7'b0000_00_1;
        tbl[14] = 7'b0000_00_0;
        ir = mkreq(64'h8000_0000, 1'b0);
        dr = mkreq(64'h0000_1000, 1'b1);
        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (i > 0) step();
            bus.ireq  = tbl[i].iv ? ir : '0;
            bus.dreq  = tbl[i].dv ? dr : '0;
            bus.oresp = '{ready: tbl[i].rdy, last: tbl[i].lst, data: 64'h13};
            #1;
            chk_all($sformatf("vec%0d", i), int'(tbl[i].own), tbl[i].busy);
        end
        // both requesters held valid for six back-to-back transactions
        do_reset();
        bus.ireq = ir;
        bus.dreq = dr;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                step();
                bus.oresp = '0;
                #1;
                n++;
            end while (bus.owner == 2'd0 && n < 10);
`ifdef CBUS_ARB_RR_EN
            exp_own = k % 2 == 0 ? 2 : 1;
`else
            exp_own = 2;
`endif
            chk($sformatf("grant_order%0d", k), 160'(bus.owner), 160'(exp_own));
            chk($sformatf("grant_latency%0d", k), 160'(n), 160'(k == 0 ? 1 : 3));
            chk($sformatf("grant_addr%0d", k), 160'(bus.oreq.addr), 160'(exp_own == 2 ? dr.addr : ir.addr));
            bus.oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
        end
        // four-beat data burst, grant held until the beat carrying last
        do_reset();
        br       = dr;
        br.len   = MLEN4;
        bus.dreq = br;
        step();
        #1;
        chk("burst_grant", 160'(bus.owner), 160'(2));
        for (int b = 0; b < 4; b++) begin
            bus.oresp = '{ready: 1'b1, last: b == 3, data: 64'(b + 100)};
            #1;
            chk($sformatf("burst_beat%0d", b), 160'(bus.dresp), {94'd0, 1'b1, b == 3, 64'(b + 100)});
            chk($sformatf("burst_owner%0d", b), 160'(bus.owner), 160'(2));
            step();
        end
        bus.oresp = '0;
        bus.dreq  = '0;
        #1;
        chk("burst_gap_owner", 160'(bus.owner), 160'(0));
        chk("burst_gap_busy", 160'(bus.busy), 160'(1));
        step();
        #1;
        chk("burst_idle_busy", 160'(bus.busy), 160'(0));
        // reset dropped in the middle of a fetch grant
        do_reset();
        bus.ireq = ir;
        step();
        #1;
        chk("arst_grant", 160'(bus.owner), 160'(1));
        bus.oresp = '{ready: 1'b1, last: 1'b0, data: 64'h55};
        #1;
        chk("arst_pre_ready", 160'(bus.iresp.ready), 160'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_oreq_valid", 160'(bus.oreq.valid), 160'(0));
        chk("arst_iresp_ready", 160'(bus.iresp.ready), 160'(0));
        chk("arst_busy", 160'(bus.busy), 160'(0));
        step();
        step();
        rst_n     = 1'b1;
        bus.oresp = '0;
        step();
        #1;
        chk("arst_regrant", 160'(bus.owner), 160'(1));
        // randomized traffic against the reference model
        do_reset();
        m_own  = 0;
        m_gap  = 1'b0;
        m_last = 1;
        fin_i  = 1'b0;
        fin_d  = 1'b0;
        for (int c = 0; c < 800; c++) begin
            step();
            if (fin_i) bus.ireq = $urandom_range(0, 1) == 1 ? mkreq({$urandom, $urandom}, 1'b0) : '0;
            else if (!bus.ireq.valid && $urandom_range(0, 2) == 0) bus.ireq = mkreq({$urandom, $urandom}, 1'b0);
            if (fin_d) bus.dreq = $urandom_range(0, 1) == 1 ? mkreq({$urandom, $urandom}, 1'($urandom_range(0, 1))) : '0;
            else if (!bus.dreq.valid && $urandom_range(0, 2) == 0) bus.dreq = mkreq({$urandom, $urandom}, 1'($urandom_range(0, 1)));
            bus.oresp.ready = 1'($urandom_range(0, 1));
            bus.oresp.last  = $urandom_range(0, 3) == 0;
            bus.oresp.data  = {$urandom, $urandom};
            #1;
            chk_all($sformatf("rand%0d", c), m_own, m_own != 0 || m_gap);
            fin_i = 1'b0;
            fin_d = 1'b0;
            if (m_own != 0) begin
                if (bus.oresp.ready && bus.oresp.last) begin
                    fin_i  = m_own == 1;
                    fin_d  = m_own == 2;
                    m_last = m_own;
                    m_own  = 0;
                    m_gap  = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (bus.ireq.valid && bus.dreq.valid) begin
`ifdef CBUS_ARB_RR_EN
                m_own = m_last == 2 ? 1 : 2;
`else
                m_own = 2;
`endif
            end else if (bus.dreq.valid) begin
                m_own = 2;
            end else if (bus.ireq.valid) begin
                m_own = 1;
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
